// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the memory access controller.
package mem_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: a lone request wins outright, a tie goes to
// whichever requester did not own the previous access.
module rr_arb2
    import mem_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       grant_valid,
    output logic       grant_owner
);
    // req[0] is fetch, req[1] is data
    always_comb begin
        grant_valid = |req;
        grant_owner = logic'(OWN_FETCH);
        if (req == 2'b10) begin
            grant_owner = logic'(OWN_DATA);
        end else if (req == 2'b11 && last_owner == logic'(OWN_FETCH)) begin
            grant_owner = logic'(OWN_DATA);
        end
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// Shares one memory port and the MAR between instruction fetch and data
// load/store, holding the read/write strobe for MEM_LATENCY cycles per access.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,
    output logic [ADDR_W-1:0] mar_addr,
    output logic              mar_load,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    // state | meaning
    // IDLE  | waiting for a request; arbiter result sampled each edge
    // ADDR  | owner's gnt and MAR load strobe asserted for one cycle
    // WAIT  | mem_re or mem_we held for MEM_LATENCY cycles
    // RESP  | owner's rvalid pulse, last_owner updated

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_t            state;
    owner_t            owner;
    owner_t            last_owner;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt;
    logic              grant_valid;
    logic              grant_owner;

    rr_arb2 u_arb (
        .req         ({data_req, fetch_req}),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign mar_addr = addr_q;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            owner        <= OWN_FETCH;
            last_owner   <= OWN_DATA;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            cnt          <= '0;
            fetch_gnt    <= 1'b0;
            data_gnt     <= 1'b0;
            fetch_rvalid <= 1'b0;
            data_rvalid  <= 1'b0;
            fetch_rdata  <= '0;
            data_rdata   <= '0;
            mar_load     <= 1'b0;
            mem_re       <= 1'b0;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner     <= owner_t'(grant_owner);
                        addr_q    <= (grant_owner == logic'(OWN_FETCH)) ? fetch_addr : data_addr;
                        we_q      <= (grant_owner == logic'(OWN_DATA)) && data_we;
                        wdata_q   <= data_wdata;
                        fetch_gnt <= (grant_owner == logic'(OWN_FETCH));
                        data_gnt  <= (grant_owner == logic'(OWN_DATA));
                        mar_load  <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    fetch_gnt <= 1'b0;
                    data_gnt  <= 1'b0;
                    mar_load  <= 1'b0;
                    cnt       <= CNT_W'(MEM_LATENCY - 1);
                    mem_re    <= !we_q;
                    mem_we    <= we_q;
                    mem_wdata <= we_q ? wdata_q : '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        mem_re    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        if (!we_q) begin
                            if (owner == OWN_FETCH) fetch_rdata <= mem_rdata;
                            else                    data_rdata  <= mem_rdata;
                        end
                        fetch_rvalid <= (owner == OWN_FETCH);
                        data_rvalid  <= (owner == OWN_DATA);
                        state        <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    fetch_rvalid <= 1'b0;
                    data_rvalid  <= 1'b0;
                    last_owner   <= owner;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus a random
// two-requester run checked against a transaction-level timing/memory model.
module tb_mem_access_ctrl;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_addr = '0;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [15:0] data_addr = '0;
    logic [15:0] data_wdata = '0;
    logic        fetch_gnt, fetch_rvalid, data_gnt, data_rvalid;
    logic        mar_load, mem_re, mem_we, busy;
    logic [15:0] fetch_rdata, data_rdata, mar_addr, mem_wdata, mem_rdata;

    logic [15:0] phys    [256];
    logic [15:0] ref_mem [256];
    logic [15:0] aux_rdata = 16'hC3A5;

    logic        ax_req   [2];
    logic        ax_fgnt  [2];
    logic        ax_frv   [2];
    logic        ax_dgnt  [2];
    logic        ax_drv   [2];
    logic        ax_load  [2];
    logic        ax_re    [2];
    logic        ax_we    [2];
    logic        ax_busy  [2];
    logic [15:0] ax_frd   [2];
    logic [15:0] ax_drd   [2];
    logic [15:0] ax_mar   [2];
    logic [15:0] ax_wd    [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // memory behind the port: reads follow the MAR, writes land on mem_we
    assign mem_rdata = phys[mar_addr[7:0]];
    always @(posedge clk) if (mem_we === 1'b1) phys[mar_addr[7:0]] = mem_wdata;

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata), .mar_addr(mar_addr), .mar_load(mar_load),
        .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    for (genvar k = 0; k < 2; k++) begin : g_aux
        mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(k == 0 ? 1 : 5)) u_aux (
            .clk(clk), .reset(reset),
            .fetch_req(ax_req[k]), .fetch_addr(16'h0ABC), .fetch_gnt(ax_fgnt[k]),
            .fetch_rvalid(ax_frv[k]), .fetch_rdata(ax_frd[k]),
            .data_req(1'b0), .data_we(1'b0), .data_addr(16'h0000),
            .data_wdata(16'h0000), .data_gnt(ax_dgnt[k]), .data_rvalid(ax_drv[k]),
            .data_rdata(ax_drd[k]), .mar_addr(ax_mar[k]), .mar_load(ax_load[k]),
            .mem_re(ax_re[k]), .mem_we(ax_we[k]), .mem_wdata(ax_wd[k]),
            .mem_rdata(aux_rdata), .busy(ax_busy[k])
        );
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        fetch_req = 1'b0;
        data_req = 1'b0;
        ax_req[0] = 1'b0;
        ax_req[1] = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        tick;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            tick;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drain: busy=%b after %0d cycles, expected 0", busy, n);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick;
        tick;
        checks++;
        if ({fetch_gnt, fetch_rvalid, fetch_rdata, data_gnt, data_rvalid, data_rdata,
             mar_addr, mar_load, mem_re, mem_we, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b frd=%h drd=%h mar=%h ld=%b re=%b we=%b wd=%h, expected all 0",
                     fetch_gnt, data_gnt, fetch_rvalid, data_rvalid, fetch_rdata, data_rdata,
                     mar_addr, mar_load, mem_re, mem_we, mem_wdata);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_fetch;
        phys[8'h40] = 16'hBEEF;
        ref_mem[8'h40] = 16'hBEEF;
        fetch_req = 1'b1;
        fetch_addr = 16'h0040;
        tick;
        checks++;
        if ({fetch_gnt, data_gnt, mar_load, mem_re} !== 4'b1010) begin
            errors++;
            $display("FAIL fetch_grant: got gnt/dgnt/load/re=%b expected 1010", {fetch_gnt, data_gnt, mar_load, mem_re});
        end
        checks++;
        if (mar_addr !== 16'h0040) begin
            errors++;
            $display("FAIL fetch_mar: got %h expected 0040", mar_addr);
        end
        fetch_req = 1'b0;
        for (int i = 0; i < L; i++) begin
            tick;
            checks++;
            if ({mem_re, mem_we, fetch_rvalid, fetch_gnt} !== 4'b1000) begin
                errors++;
                $display("FAIL fetch_wait%0d: got re/we/rv/gnt=%b expected 1000", i, {mem_re, mem_we, fetch_rvalid, fetch_gnt});
            end
        end
        tick;
        checks++;
        if ({fetch_rvalid, data_rvalid, mem_re} !== 3'b100) begin
            errors++;
            $display("FAIL fetch_resp: got frv/drv/re=%b expected 100", {fetch_rvalid, data_rvalid, mem_re});
        end
        checks++;
        if (fetch_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL fetch_rdata: got %h expected BEEF", fetch_rdata);
        end
        tick;
        checks++;
        if ({busy, fetch_rvalid} !== 2'b00 || mar_addr !== 16'h0040) begin
            errors++;
            $display("FAIL fetch_idle: got busy/rv=%b mar=%h expected 00 and 0040", {busy, fetch_rvalid}, mar_addr);
        end
    endtask

    task automatic test_store;
        logic [15:0] old_rdata;
        old_rdata = 16'h0000;
        data_req = 1'b1;
        data_we = 1'b1;
        data_addr = 16'h1234;
        data_wdata = 16'h00FF;
        ref_mem[8'h34] = 16'h00FF;
        tick;
        checks++;
        if ({data_gnt, fetch_gnt, mar_load} !== 3'b101 || mar_addr !== 16'h1234) begin
            errors++;
            $display("FAIL store_grant: got dgnt/fgnt/load=%b mar=%h expected 101 and 1234", {data_gnt, fetch_gnt, mar_load}, mar_addr);
        end
        data_req = 1'b0;
        for (int i = 0; i < L; i++) begin
            tick;
            checks++;
            if ({mem_we, mem_re} !== 2'b10 || mem_wdata !== 16'h00FF) begin
                errors++;
                $display("FAIL store_wait%0d: got we/re=%b wd=%h expected 10 and 00FF", i, {mem_we, mem_re}, mem_wdata);
            end
        end
        tick;
        checks++;
        if ({data_rvalid, fetch_rvalid, mem_we} !== 3'b100 || mem_wdata !== 16'h0000) begin
            errors++;
            $display("FAIL store_resp: got drv/frv/we=%b wd=%h expected 100 and 0000", {data_rvalid, fetch_rvalid, mem_we}, mem_wdata);
        end
        checks++;
        if (data_rdata !== old_rdata) begin
            errors++;
            $display("FAIL store_rdata_hold: got %h expected %h", data_rdata, old_rdata);
        end
        tick;
        checks++;
        if (data_rvalid !== 1'b0 || phys[8'h34] !== 16'h00FF) begin
            errors++;
            $display("FAIL store_done: got rv=%b mem=%h expected 0 and 00FF", data_rvalid, phys[8'h34]);
        end
    endtask

    task automatic test_contention;
        int gc [4];
        int go [4];
        int n;
        do_reset;
        n = 0;
        fetch_req = 1'b1;
        fetch_addr = 16'h3001;
        data_req = 1'b1;
        data_we = 1'b0;
        data_addr = 16'h3002;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick;
            if (fetch_gnt === 1'b1 || data_gnt === 1'b1) begin
                gc[n] = cyc;
                go[n] = (data_gnt === 1'b1) ? 1 : 0;
                n++;
            end
        end
        fetch_req = 1'b0;
        data_req = 1'b0;
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL contention_count: got %0d grants expected 4", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (go[i] != (i % 2)) begin
                errors++;
                $display("FAIL contention_order%0d: got owner %0d expected %0d", i, go[i], i % 2);
            end
            if (i > 0) begin
                checks++;
                if (gc[i] - gc[i-1] != L + 3) begin
                    errors++;
                    $display("FAIL contention_spacing%0d: got %0d cycles expected %0d", i, gc[i] - gc[i-1], L + 3);
                end
            end
        end
        drain;
    endtask

    task automatic test_reset_midop;
        logic saw_rv;
        int n;
        fetch_req = 1'b1;
        fetch_addr = 16'h0005;
        tick;
        fetch_req = 1'b0;
        drain;
        data_req = 1'b1;
        data_we = 1'b0;
        data_addr = 16'h0010;
        tick;
        checks++;
        if (data_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midop_grant: got %b expected 1", data_gnt);
        end
        data_req = 1'b0;
        tick;
        checks++;
        if (mem_re !== 1'b1) begin
            errors++;
            $display("FAIL midop_re: got %b expected 1", mem_re);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_re, busy} !== 2'b00) begin
            errors++;
            $display("FAIL midop_async_drop: got re/busy=%b expected 00", {mem_re, busy});
        end
        @(negedge clk);
        cyc++;
        tick;
        reset = 1'b1;
        saw_rv = 1'b0;
        for (int i = 0; i < L + 4; i++) begin
            tick;
            if (data_rvalid === 1'b1 || fetch_rvalid === 1'b1) saw_rv = 1'b1;
        end
        checks++;
        if (saw_rv !== 1'b0) begin
            errors++;
            $display("FAIL midop_no_rvalid: got %b expected 0", saw_rv);
        end
        fetch_req = 1'b1;
        data_req = 1'b1;
        n = 0;
        while (fetch_gnt !== 1'b1 && data_gnt !== 1'b1 && n < 5) begin
            tick;
            n++;
        end
        checks++;
        if ({fetch_gnt, data_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL midop_first_tie: got fgnt/dgnt=%b expected 10", {fetch_gnt, data_gnt});
        end
        fetch_req = 1'b0;
        data_req = 1'b0;
        drain;
    endtask

    task automatic test_busy_arrival;
        int g;
        do_reset;
        fetch_req = 1'b1;
        fetch_addr = 16'h0002;
        tick;
        g = cyc;
        fetch_req = 1'b0;
        tick;
        data_req = 1'b1;
        data_we = 1'b0;
        data_addr = 16'h0003;
        for (int i = 0; i < L + 2; i++) begin
            tick;
            checks++;
            if (data_gnt !== ((cyc == g + L + 3) ? 1'b1 : 1'b0) || (data_gnt === 1'b1 && fetch_rvalid === 1'b1)) begin
                errors++;
                $display("FAIL busy_arrival cyc+%0d: got dgnt=%b frv=%b expected dgnt=%b", cyc - g, data_gnt, fetch_rvalid, (cyc == g + L + 3));
            end
            if (data_gnt === 1'b1) data_req = 1'b0;
        end
        data_req = 1'b0;
        drain;
    endtask

    task automatic test_latency;
        int g [2];
        int rv [2];
        int nre [2];
        int lat;
        do_reset;
        for (int k = 0; k < 2; k++) begin
            g[k] = -100;
            rv[k] = -1;
            nre[k] = 0;
            ax_req[k] = 1'b1;
        end
        for (int c = 0; c < 20; c++) begin
            tick;
            for (int k = 0; k < 2; k++) begin
                if (ax_fgnt[k] === 1'b1) begin
                    g[k] = c;
                    ax_req[k] = 1'b0;
                end
                if (ax_re[k] === 1'b1) nre[k]++;
                if (ax_frv[k] === 1'b1) rv[k] = c;
            end
        end
        for (int k = 0; k < 2; k++) begin
            lat = (k == 0) ? 1 : 5;
            checks++;
            if (nre[k] != lat) begin
                errors++;
                $display("FAIL latency%0d_re_cycles: got %0d expected %0d", lat, nre[k], lat);
            end
            checks++;
            if (rv[k] - g[k] != lat + 1) begin
                errors++;
                $display("FAIL latency%0d_gnt_to_rvalid: got %0d expected %0d", lat, rv[k] - g[k], lat + 1);
            end
            checks++;
            if (ax_frd[k] !== aux_rdata || ax_mar[k] !== 16'h0ABC) begin
                errors++;
                $display("FAIL latency%0d_data: got rdata=%h mar=%h expected %h and 0ABC", lat, ax_frd[k], ax_mar[k], aux_rdata);
            end
            checks++;
            if ({ax_dgnt[k], ax_drv[k], ax_we[k], ax_busy[k], ax_load[k], ax_drd[k], ax_wd[k]} !== '0) begin
                errors++;
                $display("FAIL latency%0d_quiet: got dgnt=%b drv=%b we=%b busy=%b load=%b drd=%h wd=%h expected all 0",
                         lat, ax_dgnt[k], ax_drv[k], ax_we[k], ax_busy[k], ax_load[k], ax_drd[k], ax_wd[k]);
            end
        end
    endtask

    task automatic test_random;
        logic        pend_f, pend_d, act, t_we, last_own, own;
        int          g, d, idle_from;
        logic [15:0] t_addr, t_wdata, exp_mar, exp_fr, exp_dr, exp_wd;
        logic [7:0]  got_v, exp_v;
        do_reset;
        pend_f = 1'b0;
        pend_d = 1'b0;
        act = 1'b0;
        t_we = 1'b0;
        own = 1'b0;
        last_own = 1'b1;
        g = 0;
        idle_from = cyc;
        t_addr = '0;
        t_wdata = '0;
        exp_mar = '0;
        exp_fr = '0;
        exp_dr = '0;
        for (int k = 0; k < 800; k++) begin
            d = act ? cyc - g : -1;
            exp_v = '0;
            exp_wd = '0;
            if (act) begin
                exp_v[7] = (d == 0) && !own;
                exp_v[6] = (d == 0) && own;
                exp_v[5] = (d == 0);
                exp_v[4] = (d >= 1) && (d <= L) && !t_we;
                exp_v[3] = (d >= 1) && (d <= L) && t_we;
                exp_v[2] = (d == L + 1) && !own;
                exp_v[1] = (d == L + 1) && own;
                exp_v[0] = (d <= L + 1);
                exp_wd = exp_v[3] ? t_wdata : 16'h0000;
                exp_mar = t_addr;
                if (d == L + 1 && !t_we) begin
                    if (!own) exp_fr = ref_mem[t_addr[7:0]];
                    else      exp_dr = ref_mem[t_addr[7:0]];
                end
            end
            got_v = {fetch_gnt, data_gnt, mar_load, mem_re, mem_we, fetch_rvalid, data_rvalid, busy};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL rand_strobes cyc %0d: got fg/dg/ld/re/we/frv/drv/busy=%b expected %b", cyc, got_v, exp_v);
            end
            checks++;
            if (mar_addr !== exp_mar || mem_wdata !== exp_wd) begin
                errors++;
                $display("FAIL rand_addr_wdata cyc %0d: got mar=%h wd=%h expected %h and %h", cyc, mar_addr, mem_wdata, exp_mar, exp_wd);
            end
            checks++;
            if (fetch_rdata !== exp_fr || data_rdata !== exp_dr) begin
                errors++;
                $display("FAIL rand_rdata cyc %0d: got frd=%h drd=%h expected %h and %h", cyc, fetch_rdata, data_rdata, exp_fr, exp_dr);
            end
            if (act && d == 0) begin
                if (!own) pend_f = 1'b0;
                else      pend_d = 1'b0;
            end
            if (act && d == L + 1) begin
                act = 1'b0;
                last_own = own;
                idle_from = cyc + 1;
            end
            if (!pend_f && $urandom_range(0, 3) == 0) begin
                pend_f = 1'b1;
                fetch_addr = 16'h3000 | 16'($urandom_range(0, 15));
            end
            if (!pend_d && $urandom_range(0, 3) == 0) begin
                pend_d = 1'b1;
                data_addr = 16'h3000 | 16'($urandom_range(0, 15));
                data_we = 1'($urandom_range(0, 1));
                data_wdata = 16'($urandom);
            end
            fetch_req = pend_f;
            data_req = pend_d;
            if (!act && cyc >= idle_from && (pend_f || pend_d)) begin
                own = (pend_f && pend_d) ? !last_own : !pend_f;
                act = 1'b1;
                g = cyc + 1;
                t_addr = own ? data_addr : fetch_addr;
                t_we = own && data_we;
                t_wdata = data_wdata;
                if (t_we) ref_mem[t_addr[7:0]] = t_wdata;
            end
            tick;
        end
        fetch_req = 1'b0;
        data_req = 1'b0;
        drain;
    endtask

    initial begin
        logic [15:0] v;
        ax_req[0] = 1'b0;
        ax_req[1] = 1'b0;
        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            phys[i] = v;
            ref_mem[i] = v;
        end
        test_reset;
        test_fetch;
        test_store;
        test_contention;
        test_reset_midop;
        test_busy_arrival;
        test_latency;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
